// File: rtl/prefetch_queue.sv
// Instruction-byte prefetch queue. Fetches 16-bit words from PS:PC over a
// req/ack bus port and presents a head-aligned byte window to the
// pre-decoder, which retires a variable number of bytes per cycle.
module prefetch_queue #(
   parameter int DEPTH = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               fetch_en,
   input  logic               flush,
   input  logic [15:0]        flush_ps,
   input  logic [15:0]        flush_pc,
   output logic               fetch_req,
   output logic [19:0]        fetch_addr,
   input  logic               fetch_ack,
   input  logic [15:0]        fetch_data,
   output logic [8*DEPTH-1:0] q_bytes,
   output logic [3:0]         q_count,
   output logic [15:0]        q_pc,
   input  logic [3:0]         consume
);

   localparam logic [3:0] DEPTH_L = 4'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               req_next;
   logic [15:0]        fetch_ps;
   logic [15:0]        fetch_pc;
   logic [3:0]         consume_eff;
   logic [3:0]         kept;
   logic [3:0]         need;
   logic [3:0]         count_next;
   logic               take;
   logic               issue;
   logic [15:0]        word;
   logic [8*DEPTH-1:0] bytes_next;

   // Datapath: retire consumed bytes, append fetched bytes, decide on a new fetch.
   // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
   always_comb begin
      // An over-consume is clamped so the queue empties rather than wrapping.
      consume_eff = (consume > q_count) ? q_count : consume;
      kept        = q_count - consume_eff;
      // An odd PC returns only the high byte of the word.
      need        = fetch_pc[0] ? 4'd1 : 4'd2;
      word        = fetch_pc[0] ? {8'h00, fetch_data[15:8]} : fetch_data;
      take        = (state == WAIT) && fetch_ack && !flush;
      count_next  = kept + (take ? need : 4'd0);
      // Space is judged after this cycle's retirement, so issuing resumes right after a consume.
      issue       = (state == IDLE) && fetch_en && !flush && ((DEPTH_L - kept) >= need);
      // Bytes above q_count are always zero, so the right shift leaves a clean tail for the append.
      bytes_next  = q_bytes >> {consume_eff, 3'b000};
      if (take) begin
         bytes_next = bytes_next | ({{(8*DEPTH-16){1'b0}}, word} << {kept, 3'b000});
      end
   end

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         fetch_req <= 1'b0;
      end else begin
         state     <= state_next;
         fetch_req <= req_next;
      end
   end

   // FSM next state: a flush never aborts a bus cycle, it only marks the data for discard.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (issue) state_next = WAIT;
         end
         WAIT: begin
            if (fetch_ack)  state_next = IDLE;
            else if (flush) state_next = DISCARD;
         end
         DISCARD: begin
            if (fetch_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: the request is held for as long as a bus cycle is open.
   always_comb begin
      req_next = (state_next != IDLE);
   end

   // Queue window, head PC, fetch pointer and registered bus address.
   // NOTE: the byte window is reset along with the rest because unused bytes must read as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_bytes    <= '0;
         q_count    <= 4'd0;
         q_pc       <= 16'h0000;
         fetch_ps   <= 16'h0000;
         fetch_pc   <= 16'h0000;
         fetch_addr <= 20'h00000;
      end else begin
         if (flush) begin
            q_bytes  <= '0;
            q_count  <= 4'd0;
            q_pc     <= flush_pc;
            fetch_ps <= flush_ps;
            fetch_pc <= flush_pc;
         end else begin
            q_bytes <= bytes_next;
            q_count <= count_next;
            q_pc    <= q_pc + {12'h000, consume_eff};
            // PC wraps within the segment; PS never changes here.
            if (take) fetch_pc <= fetch_pc + {12'h000, need};
         end
         if (issue) fetch_addr <= {fetch_ps, 4'h0} + {4'h0, fetch_pc};
      end
   end

   // Retiring more bytes than are present is a pre-decoder bug.
   a_no_underflow : assert property (@(posedge clk) disable iff (!reset_n)
      !flush |-> (consume <= q_count))
      else $error("prefetch_queue: consume exceeds q_count");

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: a cycle table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_prefetch_queue;

   localparam int DEPTH = 6;

   logic               clk;
   logic               reset_n;
   logic               fetch_en;
   logic               flush;
   logic [15:0]        flush_ps;
   logic [15:0]        flush_pc;
   logic               fetch_req;
   logic [19:0]        fetch_addr;
   logic               fetch_ack;
   logic [15:0]        fetch_data;
   logic [8*DEPTH-1:0] q_bytes;
   logic [3:0]         q_count;
   logic [15:0]        q_pc;
   logic [3:0]         consume;

   int n_checks = 0;
   int n_errors = 0;

   prefetch_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .fetch_en   (fetch_en),
      .flush      (flush),
      .flush_ps   (flush_ps),
      .flush_pc   (flush_pc),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .fetch_ack  (fetch_ack),
      .fetch_data (fetch_data),
      .q_bytes    (q_bytes),
      .q_count    (q_count),
      .q_pc       (q_pc),
      .consume    (consume)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic [15:0] ps;
      logic [15:0] pc;
      logic        en;
      logic [3:0]  cons;
      logic        ack;
      logic [15:0] data;
      logic        req;
      logic [19:0] addr;
      logic [3:0]  cnt;
      logic [15:0] qpc;
      logic [47:0] bytes;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic [15:0] ps, input logic [15:0] pc,
                        input logic en, input logic [3:0] cons, input logic ack,
                        input logic [15:0] data);
      flush      = f;
      flush_ps   = ps;
      flush_pc   = pc;
      fetch_en   = en;
      consume    = cons;
      fetch_ack  = ack;
      fetch_data = data;
   endtask

   task automatic do_reset();
      drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0);
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic expect_out(input string tag, input logic req, input logic [19:0] addr,
                             input logic [3:0] cnt, input logic [15:0] qpc);
      check({tag, ".req"},   64'(fetch_req),  64'(req));
      check({tag, ".addr"},  64'(fetch_addr), 64'(addr));
      check({tag, ".count"}, 64'(q_count),    64'(cnt));
      check({tag, ".q_pc"},  64'(q_pc),       64'(qpc));
   endtask

   // Reference model state: a byte queue plus bus-cycle bookkeeping.
   logic [7:0]  mq[$];
   logic        m_pend;
   logic        m_drop;
   logic [15:0] m_qpc;
   logic [15:0] m_fps;
   logic [15:0] m_fpc;
   logic [19:0] m_addr;

   initial begin
      logic        f;
      logic        en;
      logic        ack;
      logic [3:0]  cons;
      logic [15:0] ps;
      logic [15:0] pc;
      logic [15:0] data;
      logic        pend_start;
      logic [47:0] exp_bytes;

      reset_n = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 4'd0, 1'b0, 16'h0);

      // flush, ps, pc, en, cons, ack, data, | req, addr, count, q_pc, bytes
      vecs[0]  = '{1'b1, 16'h1000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 20'h00000, 4'd0, 16'h0000, 48'h0};
      vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 20'h10000, 4'd0, 16'h0000, 48'h0};
      vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0201, 1'b0, 20'h10000, 4'd2, 16'h0000, 48'h000000000201};
      vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 20'h10002, 4'd2, 16'h0000, 48'h000000000201};
      vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0403, 1'b0, 20'h10002, 4'd4, 16'h0000, 48'h000004030201};
      vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 20'h10004, 4'd4, 16'h0000, 48'h000004030201};
      vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0605, 1'b0, 20'h10004, 4'd6, 16'h0000, 48'h060504030201};
      vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 20'h10004, 4'd6, 16'h0000, 48'h060504030201};
      vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd2, 1'b0, 16'h0000, 1'b1, 20'h10006, 4'd4, 16'h0002, 48'h000006050403};
      vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0807, 1'b0, 20'h10006, 4'd6, 16'h0002, 48'h080706050403};
      vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 20'h10006, 4'd6, 16'h0002, 48'h080706050403};
      vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd2, 1'b0, 16'h0000, 1'b1, 20'h10008, 4'd4, 16'h0004, 48'h000008070605};
      vecs[12] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h0A09, 1'b0, 20'h10008, 4'd3, 16'h0007, 48'h0000000A0908};
      vecs[13] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 20'h1000A, 4'd3, 16'h0007, 48'h0000000A0908};
      vecs[14] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0C0B, 1'b0, 20'h1000A, 4'd5, 16'h0007, 48'h000C0B0A0908};
      vecs[15] = '{1'b1, 16'h1000, 16'h0003, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 20'h1000A, 4'd0, 16'h0003, 48'h0};
      vecs[16] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 20'h10003, 4'd0, 16'h0003, 48'h0};
      vecs[17] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'hEEDD, 1'b0, 20'h10003, 4'd1, 16'h0003, 48'h0000000000EE};
      vecs[18] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 20'h10004, 4'd1, 16'h0003, 48'h0000000000EE};
      vecs[19] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h2211, 1'b0, 20'h10004, 4'd3, 16'h0003, 48'h0000002211EE};

      // Reset state, sampled while reset is still asserted.
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 1'b0, 20'h00000, 4'd0, 16'h0000);
      check("reset.bytes", 64'(q_bytes), 64'h0);
      reset_n = 1'b1;

      // Cycle table: fill to full, consume under a full queue, consume+ack together, odd PC flush.
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].flush, vecs[i].ps, vecs[i].pc, vecs[i].en, vecs[i].cons,
               vecs[i].ack, vecs[i].data);
         tick();
         expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].cnt, vecs[i].qpc);
         check($sformatf("vec%0d.bytes", i), 64'(q_bytes), 64'(vecs[i].bytes));
      end

      // Flush while a fetch is outstanding; the late ack is dropped.
      do_reset();
      drive(1'b1, 16'h2000, 16'h0010, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      expect_out("disc.issue", 1'b1, 20'h20010, 4'd0, 16'h0010);
      drive(1'b1, 16'h3000, 16'h0020, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      expect_out("disc.flush", 1'b1, 20'h20010, 4'd0, 16'h0020);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      tick();
      expect_out("disc.hold", 1'b1, 20'h20010, 4'd0, 16'h0020);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'hBEEF); tick();
      expect_out("disc.drop", 1'b0, 20'h20010, 4'd0, 16'h0020);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      expect_out("disc.reissue", 1'b1, 20'h30020, 4'd0, 16'h0020);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h1234); tick();
      expect_out("disc.fill", 1'b0, 20'h30020, 4'd2, 16'h0020);
      check("disc.bytes", 64'(q_bytes), 64'h1234);

      // Segment wrap: even word at FFFE, then odd byte at FFFF.
      do_reset();
      drive(1'b1, 16'hF000, 16'hFFFE, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      expect_out("wrap.issue", 1'b1, 20'hFFFFE, 4'd0, 16'hFFFE);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h5566); tick();
      expect_out("wrap.fill", 1'b0, 20'hFFFFE, 4'd2, 16'hFFFE);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd2, 1'b0, 16'h0); tick();
      expect_out("wrap.next", 1'b1, 20'hF0000, 4'd0, 16'h0000);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0000); tick();
      drive(1'b1, 16'hF000, 16'hFFFF, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      expect_out("wrap.odd", 1'b1, 20'hFFFFF, 4'd0, 16'hFFFF);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h7788); tick();
      expect_out("wrap.oddfill", 1'b0, 20'hFFFFF, 4'd1, 16'hFFFF);
      check("wrap.oddbytes", 64'(q_bytes), 64'h77);
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      expect_out("wrap.oddnext", 1'b1, 20'hF0000, 4'd1, 16'hFFFF);

      // Asynchronous reset in the middle of a bus cycle.
      do_reset();
      drive(1'b1, 16'h1000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, 16'h0); tick();
      check("areset.before", 64'(fetch_req), 64'h1);
      #2 reset_n = 1'b0;
      #1;
      check("areset.req", 64'(fetch_req), 64'h0);
      check("areset.addr", 64'(fetch_addr), 64'h0);
      #3 reset_n = 1'b1;

      // Randomized traffic against the reference model.
      do_reset();
      mq.delete();
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_qpc  = 16'h0;
      m_fps  = 16'h0;
      m_fpc  = 16'h0;
      m_addr = 20'h0;
      for (int c = 0; c < 3000; c++) begin
         exp_bytes = '0;
         for (int i = 0; i < mq.size(); i++) exp_bytes[8*i +: 8] = mq[i];
         expect_out($sformatf("rnd%0d", c), m_pend, m_addr, 4'(mq.size()), m_qpc);
         check($sformatf("rnd%0d.bytes", c), 64'(q_bytes), 64'(exp_bytes));

         f    = ($urandom_range(0, 19) == 0);
         en   = ($urandom_range(0, 7) != 0);
         cons = 4'($urandom_range(0, mq.size()));
         ack  = m_pend && ($urandom_range(0, 2) == 0);
         data = 16'($urandom);
         ps   = 16'($urandom);
         pc   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
         drive(f, ps, pc, en, cons, ack, data);

         // Advance the model by one clock.
         if (f) begin
            if (m_pend) begin
               if (ack) begin
                  m_pend = 1'b0;
                  m_drop = 1'b0;
               end else begin
                  m_drop = 1'b1;
               end
            end
            mq.delete();
            m_qpc = pc;
            m_fps = ps;
            m_fpc = pc;
         end else begin
            pend_start = m_pend;
            repeat (cons) void'(mq.pop_front());
            m_qpc = m_qpc + 16'(cons);
            if (ack) begin
               if (!m_drop) begin
                  if (m_fpc[0]) begin
                     mq.push_back(data[15:8]);
                  end else begin
                     mq.push_back(data[7:0]);
                     mq.push_back(data[15:8]);
                  end
                  m_fpc = m_fpc + (m_fpc[0] ? 16'd1 : 16'd2);
               end
               m_drop = 1'b0;
               m_pend = 1'b0;
            end
            if (!pend_start && en && ((DEPTH - mq.size()) >= (m_fpc[0] ? 1 : 2))) begin
               m_pend = 1'b1;
               m_addr = {m_fps, 4'h0} + {4'h0, m_fpc};
            end
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
